// File: rtl/usb_config_loader.sv
// Byte-stream configuration loader: hunts for a sync word, takes a load command and
// a 16-bit word count, then emits the big-endian 32-bit config words one strobe at a time.
module usb_config_loader #(
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
    parameter logic [7:0]  CMD_LOAD       = 8'h81,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        ComActive,
    output logic [7:0]  Command,
    output logic        ReceiveLED,
    output logic        Error,
    output logic [2:0]  FsmState
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        CMD    = 3'd1,
        LEN_HI = 3'd2,
        LEN_LO = 3'd3,
        DATA   = 3'd4,
        STROBE = 3'd5
    } state_t;

    state_t        state;
    logic [31:0]   syncWindow;
    logic [23:0]   wordBuf;
    logic [1:0]    byteIdx;
    logic [15:0]   wordsLeft;
    logic [TW-1:0] idleTimer;
    logic          accept;
    logic          sessionIdle;

    // Handshake: a byte transfers on any rising edge where rx_valid && rx_ready.
    // rx_ready is low only in STROBE and while reset is held.
    assign rx_ready    = !reset && (state != STROBE);
    assign accept      = rx_valid && rx_ready;
    assign FsmState    = state;
    assign sessionIdle = !accept && (state != HUNT) && (state != STROBE)
                         && (idleTimer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= HUNT;
            syncWindow  <= '0;
            wordBuf     <= '0;
            byteIdx     <= '0;
            wordsLeft   <= '0;
            idleTimer   <= '0;
            WriteData   <= '0;
            WriteStrobe <= 1'b0;
            ComActive   <= 1'b0;
            Command     <= '0;
            ReceiveLED  <= 1'b0;
            Error       <= 1'b0;
        end else begin
            WriteStrobe <= 1'b0;
            Error       <= 1'b0;
            if (accept) begin
                ReceiveLED <= ~ReceiveLED;
                idleTimer  <= '0;
            end else if (state != HUNT && state != STROBE) begin
                idleTimer <= idleTimer + TW'(1);
            end

            case (state)
                HUNT: if (accept) begin
                    if ({syncWindow[23:0], rx_data} == SYNC_WORD) begin
                        syncWindow <= '0;
                        state      <= CMD;
                        ComActive  <= 1'b1;
                    end else begin
                        syncWindow <= {syncWindow[23:0], rx_data};
                    end
                end
                CMD: if (accept) begin
                    Command <= rx_data;
                    if (rx_data == CMD_LOAD) begin
                        state <= LEN_HI;
                    end else begin
                        state     <= HUNT;
                        ComActive <= 1'b0;
                        Error     <= 1'b1;
                    end
                end
                LEN_HI: if (accept) begin
                    wordsLeft[15:8] <= rx_data;
                    state           <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    wordsLeft[7:0] <= rx_data;
                    byteIdx        <= '0;
                    // A zero-length load closes the session quietly.
                    if ({wordsLeft[15:8], rx_data} == 16'd0) begin
                        state     <= HUNT;
                        ComActive <= 1'b0;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (accept) begin
                    wordBuf <= {wordBuf[15:0], rx_data};
                    byteIdx <= byteIdx + 2'd1;
                    if (byteIdx == 2'd3) begin
                        WriteData   <= {wordBuf, rx_data};
                        WriteStrobe <= 1'b1;
                        state       <= STROBE;
                    end
                end
                STROBE: begin
                    wordsLeft <= wordsLeft - 16'd1;
                    if (wordsLeft == 16'd1) begin
                        state     <= HUNT;
                        ComActive <= 1'b0;
                    end else begin
                        state <= DATA;
                    end
                end
                default: begin
                    state     <= HUNT;
                    ComActive <= 1'b0;
                end
            endcase

            // Stalled sender: drop the session and any partial word.
            if (sessionIdle) begin
                state     <= HUNT;
                ComActive <= 1'b0;
                Error     <= 1'b1;
                idleTimer <= '0;
                byteIdx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_usb_config_loader.sv
// Directed bench for usb_config_loader: sync hunt, load sessions, bad command,
// timeout abort, zero-length load, handshake stall and mid-session reset.
module tb_usb_config_loader;

    localparam int TOUT = 20;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        ComActive;
    logic [7:0]  Command;
    logic        ReceiveLED;
    logic        Error;
    logic [2:0]  FsmState;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int led_toggles = 0;
    int ready_low = 0;
    logic prev_led = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    usb_config_loader #(
        .SYNC_WORD(32'hFAB0_FAB1),
        .CMD_LOAD(8'h81),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .WriteData(WriteData),
        .WriteStrobe(WriteStrobe),
        .ComActive(ComActive),
        .Command(Command),
        .ReceiveLED(ReceiveLED),
        .Error(Error),
        .FsmState(FsmState)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WriteStrobe === 1'b1) begin
            strobe_cnt++;
            got_q.push_back(WriteData);
        end
        if (Error === 1'b1) err_cnt++;
        if (ReceiveLED !== prev_led) led_toggles++;
        prev_led = ReceiveLED;
    end

    always @(posedge CLK) begin
        if (!reset && rx_valid && !rx_ready) ready_low++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted, rx_valid still high.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 10) check("ready_wait", 32'(guard), 32'd0);
        @(negedge CLK);
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic drain_compare(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int s0, e0, l0, k;
        logic [7:0] sq[$];

        // Reset values while reset is held
        repeat (2) @(negedge CLK);
        check("rst_ready", rx_ready, 0);
        check("rst_wdata", WriteData, 0);
        check("rst_strobe", WriteStrobe, 0);
        check("rst_active", ComActive, 0);
        check("rst_cmd", Command, 0);
        check("rst_led", ReceiveLED, 0);
        check("rst_err", Error, 0);
        check("rst_state", FsmState, 0);
        reset = 1'b0;
        @(negedge CLK);
        check("idle_ready", rx_ready, 1);

        // Two-word load, rx_valid held high through the word boundary
        l0 = led_toggles;
        ready_low = 0;
        sq = '{8'hFA, 8'hB0, 8'hFA, 8'hB1};
        foreach (sq[i]) send_byte(sq[i]);
        check("sync_active", ComActive, 1);
        check("sync_state", FsmState, 1);
        exp_q.push_back(32'h1122_3344);
        exp_q.push_back(32'h5566_7788);
        sq = '{8'h81, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        foreach (sq[i]) send_byte(sq[i]);
        check("mid_active", ComActive, 1);
        send_byte(8'h88);
        rx_valid = 1'b0;
        check("last_strobe", WriteStrobe, 1);
        check("last_wdata", WriteData, 32'h5566_7788);
        check("last_active", ComActive, 1);
        check("strobe_ready", rx_ready, 0);
        @(negedge CLK);
        check("end_active", ComActive, 0);
        check("end_state", FsmState, 0);
        check("led_toggles", 32'(led_toggles - l0), 32'd15);
        check("ready_low", 32'(ready_low), 32'd1);
        check("load_err", 32'(err_cnt), 32'd0);
        drain_compare("load_word");

        // Leading junk and overlapping sync
        do_reset();
        sq = '{8'h00, 8'hFA, 8'hFA, 8'hB0, 8'hFA};
        foreach (sq[i]) send_byte(sq[i]);
        check("ovl_hunt", FsmState, 0);
        send_byte(8'hB1);
        check("ovl_cmd", FsmState, 1);

        // Bad command right after that sync
        e0 = err_cnt;
        send_byte(8'h7E);
        rx_valid = 1'b0;
        check("bad_err", Error, 1);
        check("bad_cmd", Command, 32'h7E);
        check("bad_active", ComActive, 0);
        check("bad_state", FsmState, 0);
        @(negedge CLK);
        check("bad_err_pulse", Error, 0);
        check("bad_err_cnt", 32'(err_cnt - e0), 32'd1);

        // Timeout after a partial word
        s0 = strobe_cnt;
        e0 = err_cnt;
        sq = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h81, 8'h00, 8'h01, 8'hAA, 8'hBB};
        send_seq(sq);
        check("to_active_pre", ComActive, 1);
        k = 0;
        while (Error !== 1'b1 && k < 5 * TOUT) begin
            @(negedge CLK);
            k++;
        end
        check("to_latency", 32'(k), 32'(TOUT));
        check("to_active", ComActive, 0);
        check("to_state", FsmState, 0);
        check("to_wdata", WriteData, 0);
        check("to_strobe", 32'(strobe_cnt - s0), 32'd0);
        @(negedge CLK);
        check("to_err_cnt", 32'(err_cnt - e0), 32'd1);

        // Zero-length load
        s0 = strobe_cnt;
        e0 = err_cnt;
        sq = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h81, 8'h00, 8'h00};
        send_seq(sq);
        check("zero_state", FsmState, 0);
        check("zero_active", ComActive, 0);
        repeat (3) @(negedge CLK);
        check("zero_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("zero_err", 32'(err_cnt - e0), 32'd0);

        // Sync pattern as payload, word count of one
        exp_q.push_back(32'hFAB0_FAB1);
        sq = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h81, 8'h00, 8'h01, 8'hFA, 8'hB0, 8'hFA, 8'hB1};
        send_seq(sq);
        @(negedge CLK);
        check("payload_state", FsmState, 0);
        drain_compare("payload_word");

        // Reset in the middle of DATA
        s0 = strobe_cnt;
        e0 = err_cnt;
        sq = '{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h81, 8'h00, 8'h01, 8'h12, 8'h34};
        send_seq(sq);
        check("pre_rst_state", FsmState, 4);
        reset = 1'b1;
        @(negedge CLK);
        check("mrst_ready", rx_ready, 0);
        check("mrst_wdata", WriteData, 0);
        check("mrst_active", ComActive, 0);
        check("mrst_cmd", Command, 0);
        check("mrst_led", ReceiveLED, 0);
        check("mrst_state", FsmState, 0);
        reset = 1'b0;
        sq = '{8'hFA, 8'hB0, 8'hFA, 8'hB1};
        send_seq(sq);
        check("post_rst_cmd", FsmState, 1);
        check("mrst_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("mrst_err", 32'(err_cnt - e0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
